// File: rtl/mp_ctrl_fsm_pkg.sv
// Shared opcode, state and strobe definitions for the 8-bit microprocessor
// multi-cycle control unit.
package mp_ctrl_fsm_pkg;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_JUMP  = 2'b11;

   localparam int unsigned WAIT_W = 4;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_WB_R   = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM    = 4'd6,
      S_WB_M   = 4'd7,
      S_JUMP   = 4'd8,
      S_HALT   = 4'd9
   } state_e;

   typedef struct packed {
      logic ir_we;
      logic pc_we;
      logic pc_src;
      logic alu_src;
      logic reg_we;
      logic reg_dst;
      logic mem_to_reg;
      logic mem_re;
      logic mem_we;
   } strobe_t;

endpackage

// File: rtl/mp_ctrl_fsm_wait_timer.sv
// Memory-wait timer: counts MEM cycles with mem_ready low and flags the
// cycle in which the TIMEOUT-th such cycle occurs.
module mp_ctrl_fsm_wait_timer
   import mp_ctrl_fsm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flag fires while the count is about to reach TIMEOUT.
   assign expired_o = count_i && (cnt_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mp_ctrl_fsm.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing,
// datapath strobes, memory-timeout halt and retired-instruction counter.
module mp_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             _clk,
   input  logic             reset,
   input  logic             run_en,
   input  logic [1:0]       opcode,
   input  logic             mem_ready,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             alu_src,
   output logic             reg_we,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             mem_re,
   output logic             mem_we,
   output logic             instr_done,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             halted,
   output logic [3:0]       state
);

   import mp_ctrl_fsm_pkg::*;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] retire_q, retire_d;
   logic             done;
   logic             tmr_clr;
   logic             tmr_cnt;
   logic             tmr_exp;
   strobe_t          stb;

   mp_ctrl_fsm_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i     (_clk),
      .reset_i   (reset),
      .clear_i   (tmr_clr),
      .count_i   (tmr_cnt),
      .expired_o (tmr_exp)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      done    = 1'b0;
      tmr_clr = 1'b0;
      tmr_cnt = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run_en) state_d = S_FETCH;
         end
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            op_d = opcode;
            case (opcode)
               OP_ADD:            state_d = S_EXEC_R;
               OP_LOAD, OP_STORE: state_d = S_ADDR;
               default:           state_d = S_JUMP;
            endcase
         end
         S_EXEC_R: state_d = S_WB_R;
         S_ADDR: begin
            tmr_clr = 1'b1;
            state_d = S_MEM;
         end
         S_MEM: begin
            // A ready response beats a simultaneous timeout.
            if (mem_ready) begin
               if (op_q == OP_LOAD) state_d = S_WB_M;
               else                 done    = 1'b1;
            end else begin
               tmr_cnt = 1'b1;
               if (tmr_exp) state_d = S_HALT;
            end
         end
         S_WB_R, S_WB_M, S_JUMP: done = 1'b1;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (done) state_d = run_en ? S_FETCH : S_IDLE;
   end

   always_comb begin
      retire_d = retire_q;
      if (done) retire_d = retire_q + 1'b1;
   end

   always_comb begin
      stb = '0;
      unique case (state_q)
         S_FETCH: begin
            stb.ir_we = 1'b1;
            stb.pc_we = 1'b1;
         end
         S_WB_R: begin
            stb.reg_we  = 1'b1;
            stb.reg_dst = 1'b1;
         end
         S_ADDR: stb.alu_src = 1'b1;
         S_MEM: begin
            stb.alu_src = 1'b1;
            stb.mem_re  = (op_q == OP_LOAD);
            stb.mem_we  = (op_q == OP_STORE);
         end
         S_WB_M: begin
            stb.reg_we     = 1'b1;
            stb.mem_to_reg = 1'b1;
         end
         S_JUMP: begin
            stb.pc_we  = 1'b1;
            stb.pc_src = 1'b1;
         end
         default: stb = '0;
      endcase
   end

   always_ff @(posedge _clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         retire_q <= retire_d;
      end
   end

   assign ir_we      = stb.ir_we;
   assign pc_we      = stb.pc_we;
   assign pc_src     = stb.pc_src;
   assign alu_src    = stb.alu_src;
   assign reg_we     = stb.reg_we;
   assign reg_dst    = stb.reg_dst;
   assign mem_to_reg = stb.mem_to_reg;
   assign mem_re     = stb.mem_re;
   assign mem_we     = stb.mem_we;
   assign instr_done = done;
   assign retire_cnt = retire_q;
   assign halted     = (state_q == S_HALT);
   assign state      = state_q;

endmodule

// File: tb/tb_mp_ctrl_fsm.sv
// Scoreboard bench for mp_ctrl_fsm: directed instruction streams, completion
// records checked by an independent monitor on every instr_done pulse.
module tb_mp_ctrl_fsm;

   localparam logic [3:0] T_IDLE  = 4'd0;
   localparam logic [3:0] T_FETCH = 4'd1;
   localparam logic [3:0] T_WB_R  = 4'd4;
   localparam logic [3:0] T_MEM   = 4'd6;
   localparam logic [3:0] T_WB_M  = 4'd7;
   localparam logic [3:0] T_JUMP  = 4'd8;
   localparam logic [3:0] T_HALT  = 4'd9;

   typedef struct {
      int         lat;
      logic [3:0] st;
      logic [7:0] ret;
      logic [5:0] sig;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       run_en;
   logic [1:0] opcode;
   logic       mem_ready;
   logic       ir_we, pc_we, pc_src, alu_src, reg_we, reg_dst;
   logic       mem_to_reg, mem_re, mem_we, instr_done, halted;
   logic [7:0] retire_cnt;
   logic [3:0] state;

   int   n_cmp = 0;
   int   n_err = 0;
   int   ret_m = 0;
   int   cyc   = 0;
   int   t0    = 0;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   mp_ctrl_fsm #(.TIMEOUT(15), .CNT_W(8)) dut (
      ._clk       (clk),
      .reset      (reset),
      .run_en     (run_en),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .alu_src    (alu_src),
      .reg_we     (reg_we),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .instr_done (instr_done),
      .retire_cnt (retire_cnt),
      .halted     (halted),
      .state      (state)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] all_out();
      return {9'd0, ir_we, pc_we, pc_src, alu_src, reg_we, reg_dst,
              mem_to_reg, mem_re, mem_we, instr_done, halted,
              state, retire_cnt};
   endfunction

   // Monitor: every completion pulse pops one expected record.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!reset) begin
         if (state == T_FETCH) t0 = cyc;
         if (instr_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("latency", 32'(cyc - t0 + 1), 32'(e.lat));
               chk("done_state", 32'(state), 32'(e.st));
               chk("done_retire", 32'(retire_cnt), 32'(e.ret));
               chk("done_strobes",
                   32'({reg_we, reg_dst, mem_to_reg, pc_we, pc_src, mem_we}),
                   32'(e.sig));
            end
         end
      end
   end

   task automatic wait_fetch();
      int n;
      n = 0;
      while (state != T_FETCH && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("fetch_timeout", 32'(state), 32'(T_FETCH));
   endtask

   task automatic issue(input logic [1:0] op, input int stall,
                        input bit drop, output logic [31:0] tr,
                        output int nwe, output int nre, output int nps);
      exp_t x;
      int   n, mc;
      bit   dn;
      tr = '0; nwe = 0; nre = 0; nps = 0;
      n = 0; mc = 0; dn = 1'b0;
      wait_fetch();
      opcode    = op;
      mem_ready = (stall == 0);
      case (op)
         2'b00:   x = '{4, T_WB_R, 8'(ret_m), 6'b110000};
         2'b01:   x = '{5, T_WB_M, 8'(ret_m), 6'b101000};
         2'b10:   x = '{4 + stall, T_MEM, 8'(ret_m), 6'b000001};
         default: x = '{3, T_JUMP, 8'(ret_m), 6'b000110};
      endcase
      sb.push_back(x);
      ret_m = ret_m + 1;
      while (!dn && n < 64) begin
         if (state == T_MEM) begin
            mem_ready = (mc >= stall);
            mc++;
         end
         if (drop && state == T_JUMP) run_en = 1'b0;
         @(negedge clk);
         tr  = {tr[27:0], state};
         nwe += int'(mem_we);
         nre += int'(mem_re);
         nps += int'(pc_src);
         dn  = instr_done;
         @(posedge clk); #1;
         n++;
      end
      if (!dn) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] tr;
      int nwe, nre, nps, n, mc;

      reset = 1'b1; run_en = 1'b1; opcode = 2'b00; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", all_out(), 32'd0);
      reset = 1'b0;

      // 1: single load
      issue(2'b01, 0, 1'b0, tr, nwe, nre, nps);
      chk("load_trace", tr, 32'h0001_2567);
      chk("load_mem_re_cycles", 32'(nre), 32'd1);
      chk("load_retire", 32'(retire_cnt), 32'd1);

      // 2: add, store, jump back to back
      issue(2'b00, 0, 1'b0, tr, nwe, nre, nps);
      chk("add_trace", tr, 32'h0000_1234);
      chk("add_mem_we", 32'(nwe), 32'd0);
      chk("add_pc_src", 32'(nps), 32'd0);
      issue(2'b10, 0, 1'b0, tr, nwe, nre, nps);
      chk("store_trace", tr, 32'h0000_1256);
      chk("store_mem_we", 32'(nwe), 32'd1);
      chk("store_pc_src", 32'(nps), 32'd0);
      issue(2'b11, 0, 1'b0, tr, nwe, nre, nps);
      chk("jump_trace", tr, 32'h0000_0128);
      chk("jump_mem_we", 32'(nwe), 32'd0);
      chk("jump_pc_src", 32'(nps), 32'd1);
      chk("retire_after_4", 32'(retire_cnt), 32'd4);
      chk("no_bubble_fetch", 32'(state), 32'(T_FETCH));

      // 3: store waiting five cycles on mem_ready
      issue(2'b10, 5, 1'b0, tr, nwe, nre, nps);
      chk("stall_mem_we_cycles", 32'(nwe), 32'd6);
      chk("stall_not_halted", 32'(halted), 32'd0);
      chk("stall_retire", 32'(retire_cnt), 32'd5);

      // 4: load with mem_ready stuck low
      wait_fetch();
      opcode = 2'b01; mem_ready = 1'b0;
      n = 0; mc = 0;
      while (state != T_HALT && n < 60) begin
         if (state == T_MEM) mc++;
         @(posedge clk); #1;
         n++;
      end
      chk("timeout_mem_cycles", 32'(mc), 32'd15);
      chk("halted_flag", 32'(halted), 32'd1);
      chk("halt_strobes", all_out() >> 14, 32'h0);
      for (int i = 0; i < 4; i++) begin
         run_en = i[0];
         mem_ready = 1'b1;
         @(posedge clk); #1;
         chk("halt_sticky", 32'(state), 32'(T_HALT));
      end
      run_en = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("halt_reset_state", 32'(state), 32'(T_IDLE));
      chk("halt_reset_flag", 32'(halted), 32'd0);
      chk("halt_reset_retire", 32'(retire_cnt), 32'd0);
      reset = 1'b0;
      ret_m = 0;

      // 5: reset during a store's MEM phase
      wait_fetch();
      opcode = 2'b10; mem_ready = 1'b0;
      n = 0;
      while (state != T_MEM && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_in_mem", 32'(mem_we), 32'd1);
      reset = 1'b1; run_en = 1'b0;
      @(posedge clk); #1;
      chk("abort_outputs", all_out(), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_idle", 32'({state, mem_we}), 32'({T_IDLE, 1'b0}));
      end

      // 6: 256 jumps, stop requested during the last one
      run_en = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin
         issue(2'b11, 0, (i == 255), tr, nwe, nre, nps);
      end
      chk("wrap_retire", 32'(retire_cnt), 32'd0);
      chk("stop_idle", 32'(state), 32'(T_IDLE));
      @(posedge clk); #1;
      chk("stay_idle", 32'(state), 32'(T_IDLE));

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
